// File: rtl/cpu_ctrl_pkg.sv
// Shared control-decode definitions: instruction encodings, bundle layout and
// the combinational main decoder.
package cpu_ctrl_pkg;

  localparam int CTRL_W = 12;

  localparam int B_REGWRITE  = 11;
  localparam int B_REGDST    = 10;
  localparam int B_ALUSRC    = 9;
  localparam int B_BRANCH    = 8;
  localparam int B_MEMWRITE  = 7;
  localparam int B_MEMTOREG  = 6;
  localparam int B_AL_REGDST = 5;
  localparam int B_JUMP      = 4;
  localparam int B_JUMPR     = 3;
  localparam int B_HILO_WE   = 2;
  localparam int B_MULDIV    = 1;
  localparam int B_RI        = 0;

  typedef struct packed {
    logic regwrite;
    logic regdst;
    logic alusrc;
    logic branch;
    logic memwrite;
    logic memtoreg;
    logic al_regdst;
    logic jump;
    logic jumpr;
    logic hilo_we;
    logic muldiv;
    logic ri;
  } ctrl_t;

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_REGIMM = 6'h01, OP_J    = 6'h02,
                         OP_JAL   = 6'h03, OP_BEQ    = 6'h04, OP_BNE  = 6'h05,
                         OP_BLEZ  = 6'h06, OP_BGTZ   = 6'h07, OP_ADDI = 6'h08,
                         OP_ADDIU = 6'h09, OP_SLTI   = 6'h0A, OP_SLTIU = 6'h0B,
                         OP_ANDI  = 6'h0C, OP_ORI    = 6'h0D, OP_XORI = 6'h0E,
                         OP_LUI   = 6'h0F, OP_LW     = 6'h23, OP_SW   = 6'h2B;

  localparam logic [5:0] F_SLL  = 6'h00, F_SRL  = 6'h02, F_SRA   = 6'h03,
                         F_SLLV = 6'h04, F_SRLV = 6'h06, F_SRAV  = 6'h07,
                         F_JR   = 6'h08, F_JALR = 6'h09, F_MFHI  = 6'h10,
                         F_MTHI = 6'h11, F_MFLO = 6'h12, F_MTLO  = 6'h13,
                         F_MULT = 6'h18, F_MULTU = 6'h19, F_DIV  = 6'h1A,
                         F_DIVU = 6'h1B, F_ADD  = 6'h20, F_ADDU  = 6'h21,
                         F_SUB  = 6'h22, F_SUBU = 6'h23, F_AND   = 6'h24,
                         F_OR   = 6'h25, F_XOR  = 6'h26, F_NOR   = 6'h27,
                         F_SLT  = 6'h2A, F_SLTU = 6'h2B;

  localparam logic [4:0] RT_BLTZ = 5'h00, RT_BGEZ = 5'h01,
                         RT_BLTZAL = 5'h10, RT_BGEZAL = 5'h11;

  function automatic logic is_div(input logic [5:0] funct);
    return (funct == F_DIV) || (funct == F_DIVU);
  endfunction

  function automatic ctrl_t decode(input logic [5:0] op, input logic [5:0] funct,
                                   input logic [4:0] rt, input logic en_ri);
    ctrl_t c;
    c = '0;
    case (op)
      OP_RTYPE:
        case (funct)
          F_SLL, F_SRL, F_SRA, F_SLLV, F_SRLV, F_SRAV, F_MFHI, F_MFLO,
          F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_OR, F_XOR, F_NOR,
          F_SLT, F_SLTU: begin c.regwrite = 1'b1; c.regdst = 1'b1; end
          F_JALR: begin c.regwrite = 1'b1; c.regdst = 1'b1; c.jumpr = 1'b1; end
          F_JR:   c.jumpr = 1'b1;
          F_MTHI, F_MTLO: c.hilo_we = 1'b1;
          F_MULT, F_MULTU, F_DIV, F_DIVU: begin c.hilo_we = 1'b1; c.muldiv = 1'b1; end
          default: c.ri = en_ri;
        endcase
      OP_REGIMM:
        case (rt)
          RT_BLTZ, RT_BGEZ: c.branch = 1'b1;
          RT_BLTZAL, RT_BGEZAL: begin
            c.regwrite = 1'b1; c.branch = 1'b1; c.al_regdst = 1'b1;
          end
          default: c.ri = en_ri;
        endcase
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI:
        begin c.regwrite = 1'b1; c.alusrc = 1'b1; end
      OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: c.branch = 1'b1;
      OP_J:   c.jump = 1'b1;
      OP_JAL: begin c.regwrite = 1'b1; c.jump = 1'b1; c.al_regdst = 1'b1; end
      OP_LW:  begin c.regwrite = 1'b1; c.alusrc = 1'b1; c.memtoreg = 1'b1; end
      OP_SW:  begin c.alusrc = 1'b1; c.memwrite = 1'b1; end
      default: c.ri = en_ri;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/muldiv_stall_ctr.sv
// EX occupancy counter for multi-cycle MULT/DIV; busy while the count is non-zero.
module muldiv_stall_ctr #(
  parameter int CW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          hold,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic          busy
);
  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (clear) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else if (hold) begin
      state_nxt = state;
    end else if (state == BUSY) begin
      cnt_nxt = cnt - CW'(1);
      if (cnt == CW'(1)) state_nxt = IDLE;
    end else if (load && load_val != '0) begin
      // single-cycle ops load 0 and never leave IDLE
      state_nxt = BUSY;
      cnt_nxt   = load_val;
    end
  end

  assign busy = (state == BUSY);

endmodule

// File: rtl/ctrl_decode_pipe.sv
// Main control decoder plus ID->EX->MEM->WB control pipeline with stall,
// EX flush and multi-cycle MULT/DIV occupancy.
module ctrl_decode_pipe
  import cpu_ctrl_pkg::*;
#(
  parameter int MUL_CYCLES = 1,
  parameter int DIV_CYCLES = 32,
  parameter bit ENABLE_RI  = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [5:0]  op,
  input  logic [5:0]  funct,
  input  logic [4:0]  rt,
  input  logic        stall_in,
  input  logic        flush_ex,
  output logic        id_ready,
  output logic        ex_valid,
  output logic [11:0] ex_ctrl,
  output logic        mem_valid,
  output logic        mem_regwrite,
  output logic        mem_memwrite,
  output logic        mem_memtoreg,
  output logic        wb_valid,
  output logic        wb_regwrite,
  output logic        wb_memtoreg,
  output logic        muldiv_busy,
  output logic        stall_out
);
  localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  ctrl_t         id_ctrl, ex_q;
  logic          ex_v, mem_v, wb_v;
  logic          mem_rw, mem_mw, mem_mtr, wb_rw, wb_mtr;
  logic          busy, advance, md_load;
  logic [CW-1:0] md_val;

  assign id_ctrl = decode(op, funct, rt, ENABLE_RI);
  assign advance = !stall_in && !busy;
  assign md_load = advance && !flush_ex && id_valid && id_ctrl.muldiv;
  assign md_val  = is_div(funct) ? CW'(DIV_CYCLES - 1) : CW'(MUL_CYCLES - 1);

  muldiv_stall_ctr #(.CW(CW)) u_ctr (
    .clk      (clk),
    .rst      (rst),
    .clear    (flush_ex),
    .hold     (stall_in),
    .load     (md_load),
    .load_val (md_val),
    .busy     (busy)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_v  <= 1'b0; ex_q <= '0;
      mem_v <= 1'b0; mem_rw <= 1'b0; mem_mw <= 1'b0; mem_mtr <= 1'b0;
      wb_v  <= 1'b0; wb_rw  <= 1'b0; wb_mtr <= 1'b0;
    end else begin
      // flush wins over stall for EX only; MEM/WB follow the stall rules
      if (flush_ex) begin
        ex_v <= 1'b0;
        ex_q <= '0;
      end else if (advance) begin
        ex_v <= id_valid;
        ex_q <= id_valid ? id_ctrl : '0;
      end
      if (!stall_in) begin
        if (busy) begin
          mem_v <= 1'b0; mem_rw <= 1'b0; mem_mw <= 1'b0; mem_mtr <= 1'b0;
        end else begin
          mem_v   <= ex_v;
          mem_rw  <= ex_q.regwrite;
          mem_mw  <= ex_q.memwrite;
          mem_mtr <= ex_q.memtoreg;
        end
        wb_v   <= mem_v;
        wb_rw  <= mem_rw;
        wb_mtr <= mem_mtr;
      end
    end
  end

  assign ex_valid     = ex_v;
  assign ex_ctrl      = ex_v ? ex_q : '0;
  assign mem_valid    = mem_v;
  assign mem_regwrite = mem_v & mem_rw;
  assign mem_memwrite = mem_v & mem_mw;
  assign mem_memtoreg = mem_v & mem_mtr;
  assign wb_valid     = wb_v;
  assign wb_regwrite  = wb_v & wb_rw;
  assign wb_memtoreg  = wb_v & wb_mtr;
  assign muldiv_busy  = busy;
  assign stall_out    = stall_in | busy;
  assign id_ready     = !stall_out;

endmodule

// File: tb/tb_ctrl_decode_pipe.sv
// Directed + random bench for ctrl_decode_pipe against an instruction-table
// reference model of the control pipeline.
module tb_ctrl_decode_pipe;
  localparam int MULC = 1;
  localparam int DIVC = 32;

  logic clk = 1'b0;
  logic rst, id_valid, stall_in, flush_ex;
  logic [5:0] op, funct;
  logic [4:0] rt;
  logic id_ready, ex_valid, mem_valid, mem_regwrite, mem_memwrite, mem_memtoreg;
  logic wb_valid, wb_regwrite, wb_memtoreg, muldiv_busy, stall_out;
  logic [11:0] ex_ctrl;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ctrl_decode_pipe #(.MUL_CYCLES(MULC), .DIV_CYCLES(DIVC), .ENABLE_RI(1'b1)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .op(op), .funct(funct), .rt(rt),
    .stall_in(stall_in), .flush_ex(flush_ex), .id_ready(id_ready),
    .ex_valid(ex_valid), .ex_ctrl(ex_ctrl), .mem_valid(mem_valid),
    .mem_regwrite(mem_regwrite), .mem_memwrite(mem_memwrite), .mem_memtoreg(mem_memtoreg),
    .wb_valid(wb_valid), .wb_regwrite(wb_regwrite), .wb_memtoreg(wb_memtoreg),
    .muldiv_busy(muldiv_busy), .stall_out(stall_out)
  );

  // instruction table: sel 0 = op only, 1 = op+funct, 2 = op+rt
  typedef struct {
    logic [5:0]  op;
    int          sel;
    logic [5:0]  code;
    logic [11:0] b;
    int          lat;
  } ent_t;
  ent_t tbl[$];

  task automatic add(input logic [5:0] o, input int s, input logic [5:0] c,
                     input logic [11:0] b, input int lat);
    ent_t e;
    e.op = o; e.sel = s; e.code = c; e.b = b; e.lat = lat;
    tbl.push_back(e);
  endtask

  task automatic build_table();
    logic [5:0] ralu[18] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h10, 6'h12,
                             6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                             6'h2A, 6'h2B};
    foreach (ralu[i]) add(6'h00, 1, ralu[i], 12'hC00, 0);
    add(6'h00, 1, 6'h09, 12'hC08, 0);
    add(6'h00, 1, 6'h08, 12'h008, 0);
    add(6'h00, 1, 6'h11, 12'h004, 0);
    add(6'h00, 1, 6'h13, 12'h004, 0);
    add(6'h00, 1, 6'h18, 12'h006, MULC);
    add(6'h00, 1, 6'h19, 12'h006, MULC);
    add(6'h00, 1, 6'h1A, 12'h006, DIVC);
    add(6'h00, 1, 6'h1B, 12'h006, DIVC);
    for (int o = 8; o <= 15; o++) add(6'(o), 0, 6'h00, 12'hA00, 0);
    for (int o = 4; o <= 7; o++)  add(6'(o), 0, 6'h00, 12'h100, 0);
    add(6'h01, 2, 6'h00, 12'h100, 0);
    add(6'h01, 2, 6'h01, 12'h100, 0);
    add(6'h01, 2, 6'h10, 12'h920, 0);
    add(6'h01, 2, 6'h11, 12'h920, 0);
    add(6'h02, 0, 6'h00, 12'h010, 0);
    add(6'h03, 0, 6'h00, 12'h830, 0);
    add(6'h23, 0, 6'h00, 12'hA40, 0);
    add(6'h2B, 0, 6'h00, 12'h280, 0);
  endtask

  task automatic lookup(output logic [11:0] b, output int lat);
    b = 12'h001; lat = 0;
    foreach (tbl[i]) begin
      if (tbl[i].op == op && (tbl[i].sel == 0 ||
          (tbl[i].sel == 1 && tbl[i].code == funct) ||
          (tbl[i].sel == 2 && tbl[i].code[4:0] == rt))) begin
        b = tbl[i].b; lat = tbl[i].lat;
      end
    end
  endtask

  // reference pipeline state; m_cnt = remaining stall cycles of the muldiv in EX
  logic        m_ex_v, m_mem_v, m_wb_v;
  logic [11:0] m_ex;
  logic [2:0]  m_mem;   // regwrite, memwrite, memtoreg
  logic [1:0]  m_wb;    // regwrite, memtoreg
  int          m_cnt;

  function automatic logic [22:0] obs_vec();
    return {ex_valid, ex_ctrl, mem_valid, mem_regwrite, mem_memwrite, mem_memtoreg,
            wb_valid, wb_regwrite, wb_memtoreg, muldiv_busy, stall_out, id_ready};
  endfunction

  function automatic logic [22:0] exp_vec();
    logic bz, so;
    bz = (m_cnt != 0);
    so = stall_in | bz;
    return {m_ex_v, m_ex, m_mem_v, m_mem, m_wb_v, m_wb, bz, so, !so};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    logic [11:0] b, n_ex;
    logic [2:0]  n_mem;
    logic [1:0]  n_wb;
    logic        n_ex_v, n_mem_v, n_wb_v, bz;
    int          lat, n_cnt;
    lookup(b, lat);
    bz = (m_cnt != 0);
    @(posedge clk);
    if (rst) begin
      m_ex_v = 0; m_ex = '0; m_mem_v = 0; m_mem = '0; m_wb_v = 0; m_wb = '0; m_cnt = 0;
    end else begin
      n_ex_v = m_ex_v; n_ex = m_ex; n_cnt = m_cnt;
      n_mem_v = m_mem_v; n_mem = m_mem; n_wb_v = m_wb_v; n_wb = m_wb;
      if (flush_ex) begin
        n_ex_v = 0; n_ex = '0; n_cnt = 0;
      end else if (!stall_in && bz) begin
        n_cnt = m_cnt - 1;
      end else if (!stall_in) begin
        n_ex_v = id_valid;
        n_ex   = id_valid ? b : '0;
        n_cnt  = (id_valid && lat > 1) ? lat - 1 : 0;
      end
      if (!stall_in) begin
        n_mem_v = bz ? 1'b0 : m_ex_v;
        n_mem   = bz ? 3'b000 : {m_ex[11], m_ex[7], m_ex[6]};
        n_wb_v  = m_mem_v;
        n_wb    = {m_mem[2], m_mem[0]};
      end
      m_ex_v = n_ex_v; m_ex = n_ex; m_cnt = n_cnt;
      m_mem_v = n_mem_v; m_mem = n_mem; m_wb_v = n_wb_v; m_wb = n_wb;
    end
    #1;
    check("cycle", 32'(obs_vec()), 32'(exp_vec()));
  endtask

  task automatic issue(input logic v, input logic [5:0] o, input logic [5:0] f,
                       input logic [4:0] r);
    id_valid = v; op = o; funct = f; rt = r;
  endtask

  initial begin
    int occ, k;
    build_table();
    m_ex_v = 0; m_ex = '0; m_mem_v = 0; m_mem = '0; m_wb_v = 0; m_wb = '0; m_cnt = 0;
    rst = 1; stall_in = 0; flush_ex = 0;
    issue(0, 6'h00, 6'h00, 5'h00);
    step(); step();
    check("reset_state", 32'(obs_vec()), 32'h1);
    rst = 0;

    // ADDU
    issue(1, 6'h00, 6'h21, 5'h00); step();
    check("addu_ex_ctrl", 32'(ex_ctrl), 32'hC00);
    issue(0, 6'h00, 6'h00, 5'h00); step(); step();
    check("addu_wb_regwrite", 32'(wb_regwrite), 32'h1);

    // REGIMM
    issue(1, 6'h01, 6'h00, 5'h11); step();
    check("bgezal_ex_ctrl", 32'(ex_ctrl), 32'h920);
    issue(1, 6'h01, 6'h00, 5'h05); step();
    check("regimm_ri", 32'(ex_ctrl), 32'h001);

    // LW then SW
    issue(1, 6'h23, 6'h00, 5'h00); step();
    issue(1, 6'h2B, 6'h00, 5'h00); step();
    check("lw_mem_memtoreg", 32'(mem_memtoreg), 32'h1);
    issue(0, 6'h00, 6'h00, 5'h00); step();
    check("sw_mem_memwrite", 32'(mem_memwrite), 32'h1);
    check("lw_wb_memtoreg", 32'(wb_memtoreg), 32'h1);
    step();
    check("sw_wb_memtoreg", 32'(wb_memtoreg), 32'h0);
    step(); step();

    // DIV full occupancy, ADDU waiting behind it
    issue(1, 6'h00, 6'h1A, 5'h00); step();
    issue(1, 6'h00, 6'h21, 5'h00);
    k = 0;
    for (int i = 0; i < DIVC - 1; i++) begin
      if (stall_out === 1'b1 && id_ready === 1'b0 && mem_valid === 1'b0) k++;
      step();
    end
    check("div_stall_cycles", 32'(k), 32'(DIVC - 1));
    check("div_release_stall", 32'(stall_out), 32'h0);
    check("div_still_in_ex", 32'(ex_ctrl), 32'h006);
    step();
    check("div_reaches_mem", 32'(mem_valid), 32'h1);
    issue(0, 6'h00, 6'h00, 5'h00); step(); step(); step();

    // flush on 5th busy cycle
    issue(1, 6'h00, 6'h1A, 5'h00); step();
    issue(0, 6'h00, 6'h00, 5'h00);
    for (int i = 0; i < 4; i++) step();
    flush_ex = 1; step(); flush_ex = 0;
    check("flush_busy", 32'(muldiv_busy), 32'h0);
    check("flush_ex_valid", 32'(ex_valid), 32'h0);
    k = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (mem_valid !== 1'b0) k++;
    end
    check("flush_no_mem", 32'(k), 32'h0);

    // stall_in held 4 cycles during a DIV
    issue(1, 6'h00, 6'h1B, 5'h00); step();
    issue(0, 6'h00, 6'h00, 5'h00);
    occ = 0;
    for (int i = 0; i < 100; i++) begin
      if (!(ex_valid === 1'b1 && ex_ctrl === 12'h006)) break;
      occ++;
      stall_in = (i >= 2 && i < 6);
      step();
    end
    stall_in = 0;
    check("div_stall_occupancy", 32'(occ), 32'(DIVC + 4));
    step(); step();

    // reset mid-DIV
    issue(1, 6'h00, 6'h1A, 5'h00); step();
    issue(0, 6'h00, 6'h00, 5'h00); step(); step(); step();
    rst = 1; step(); rst = 0;
    check("reset_mid_div", 32'(obs_vec()), 32'h1);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      int idx;
      rst      = ($urandom_range(0, 99) == 0);
      stall_in = ($urandom_range(0, 9) == 0);
      flush_ex = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 4) == 0) begin
        issue($urandom_range(0, 1) == 1, 6'($urandom), 6'($urandom), 5'($urandom));
      end else begin
        idx = $urandom_range(0, tbl.size() - 1);
        if (tbl[idx].lat > 1 && $urandom_range(0, 3) != 0) idx = 9;
        issue($urandom_range(0, 3) != 0, tbl[idx].op,
              tbl[idx].sel == 1 ? tbl[idx].code : 6'($urandom),
              tbl[idx].sel == 2 ? tbl[idx].code[4:0] : 5'($urandom));
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/ctrl_decode_pipe.md
# ctrl_decode_pipe

Parametrised successor to the main control decoder. It decodes `op`/`funct`/`rt` into an extended control bundle and carries that bundle through registered ID→EX→MEM→WB stages. It also handles stall and flush, and a multi-cycle MULT/DIV occupancy counter that raises a pipeline stall. It sits between instruction fetch/decode and the datapath, and replaces the purely combinational decoder plus the per-stage control flops.

## Interface
- `MUL_CYCLES`, 1, EX occupancy of MULT/MULTU in cycles (≥1).
- `DIV_CYCLES`, 32, EX occupancy of DIV/DIVU in cycles (≥1).
- `ENABLE_RI`, 1, when 0 the reserved-instruction bit is forced to 0.

Ports. One clock; reset is synchronous and active-high.
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high.
- `id_valid` in 1: ID holds a real instruction.
- `op` in 6, `funct` in 6, `rt` in 5: instruction fields.
- `stall_in` in 1: external (memory) stall; freezes all stages.
- `flush_ex` in 1: kill the instruction entering EX.
- `id_ready` out 1: ID→EX transfer accepted this cycle.
- `ex_valid` out 1, `ex_ctrl` out 12: EX-stage bundle.
- `mem_valid` out 1, `mem_regwrite`/`mem_memwrite`/`mem_memtoreg` out 1 each.
- `wb_valid` out 1, `wb_regwrite`/`wb_memtoreg` out 1 each.
- `muldiv_busy` out 1: counter non-zero.
- `stall_out` out 1: `stall_in | muldiv_busy`.

## Operation
- Bundle bit order, MSB→LSB: regwrite, regdst, alusrc, branch, memwrite, memtoreg, al_regdst, jump, jumpr, hilo_we, muldiv, ri.
- Decode is combinational and fully specified. There is no latch on unknown REGIMM `rt`.
- R-type ALU, shift and MFHI/MFLO decode to regwrite=1, regdst=1. JALR is the same plus jumpr=1.
- JR: jumpr=1 only.
- MTHI/MTLO: hilo_we=1.
- MULT/MULTU/DIV/DIVU: hilo_we=1, muldiv=1.
- I-type ALU (ANDI/ORI/XORI/LUI/ADDI/ADDIU/SLTI/SLTIU): regwrite=1, alusrc=1.
- BEQ/BNE/BGTZ/BLEZ/BLTZ/BGEZ: branch=1.
- BLTZAL/BGEZAL: regwrite=1, branch=1, al_regdst=1.
- J: jump=1. JAL: regwrite=1, jump=1, al_regdst=1.
- LW: regwrite=1, alusrc=1, memtoreg=1. SW: alusrc=1, memwrite=1.
- Any other op/funct/rt decodes to all zeros with ri=ENABLE_RI.
- When any stage's valid is 0, that stage's control outputs read 0.
- Advance rules, evaluated each edge, in priority order:
  1. `rst`: all valids 0, counter 0, bundles 0.
  2. `flush_ex`: EX loads a bubble and the counter clears. This applies even under stall. MEM/WB obey rules 3–5.
  3. `stall_in`: all stages and the counter hold.
  4. `muldiv_busy`: ID/EX hold, the counter decrements, MEM loads a bubble, WB takes MEM.
  5. Otherwise: EX←ID (valid = `id_valid`), MEM←EX, WB←MEM.
- Counter FSM:
  - IDLE (count=0).
  - IDLE→BUSY when a valid muldiv instruction is loaded into EX. The counter loads L−1, where L is DIV_CYCLES for DIV/DIVU and MUL_CYCLES for MULT/MULTU. If L=1 the counter stays IDLE.
  - BUSY→IDLE when count reaches 0, or on flush/reset.
- `id_ready` = `!stall_out`. A flush does not consume ID.

## Timing
- ID→EX latency is 1 cycle; to MEM 2 cycles; to WB 3 cycles, absent stalls.
- A DIV holds EX for exactly DIV_CYCLES cycles. `stall_out` is high for DIV_CYCLES−1 of those cycles, starting the cycle after capture.
- `muldiv_busy` and `stall_out` are combinational from the counter and `stall_in`. No registered delay.
- Simultaneous `stall_in` and a non-zero counter: the counter holds, so `stall_in` extends the muldiv occupancy.
- Back-to-back DIVs: the second is captured on the first cycle with `stall_out`=0 and restarts the counter.
- Reset mid-DIV: the next cycle shows all outputs 0 and `id_ready`=1.

## Structure
- Shared package `cpu_ctrl_pkg`:
  - op/funct/rt encodings (same values as the existing defines).
  - Bundle bit-index constants.
  - `CTRL_W`=12.
  - Bundle struct/typedef.
- Sub-module `muldiv_stall_ctr`: counter, load/decrement/clear, `busy` output, width $clog2(max(MUL_CYCLES,DIV_CYCLES)).

## Test plan
- ADDU (op=0x00, funct=0x21), `id_valid`=1 → next cycle `ex_ctrl`=12'b1100_0000_0000. Two cycles later `wb_regwrite`=1.
- BGEZAL (op=0x01, rt=0x11) → `ex_ctrl`=12'b1001_0010_0000. Unknown REGIMM rt=0x05 → `ex_ctrl`=12'b0000_0000_0001.
- LW (0x23) followed by SW (0x2B) → `mem_memtoreg`=1 at cycle 2, then `mem_memwrite`=1 at cycle 3. `wb_memtoreg` is high only for LW.
- DIV (funct=0x1A), DIV_CYCLES=32 → `stall_out` high 31 cycles, `id_ready`=0, `mem_valid`=0 throughout. The DIV reaches MEM on cycle 33.
- `flush_ex` on the 5th busy cycle of a DIV → `muldiv_busy`=0 and `ex_valid`=0 next cycle. The DIV never reaches MEM.
- `stall_in` held 4 cycles during a DIV → occupancy is 36 cycles. Separately, `rst` mid-sequence → all outputs 0 on the next cycle.
